// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, word type, round constants
// and the S-box table used by both aes_sub_word and sub_bytes.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_e;

  typedef logic [31:0] word_t;

  localparam int unsigned NUM_ROUNDS = 10;

  // Indexed by round number; entry 0 and 11..15 are unused padding.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box byte lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_in,
  output word_t word_out
);

  always_comb begin
    word_out = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      word_out[8*i +: 8] = sbox(word_in[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands a loaded cipher key into round keys 0..10,
// one per clock, and serves them through a combinational read port.
module aes_key_expansion #(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic [3:0]   round_key_addr,
  output logic [127:0] round_key_input,
  output logic [127:0] round_key_0,
  output logic         key_ready,
  output logic         key_busy
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk_q [0:NUM_ROUNDS];
  logic [127:0] rk_d [0:NUM_ROUNDS];

  logic [127:0] prev_key;
  logic [127:0] next_key;
  word_t        w0, w1, w2, w3, sub_rot, n0, n1, n2, n3;

  // Previous round key selected by an explicit mux so an idle counter of 0
  // never forms an out-of-range index.
  always_comb begin
    prev_key = '0;
    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
      if (cnt_q == 4'(i + 1)) prev_key = rk_q[i];
    end
  end

  assign {w0, w1, w2, w3} = prev_key;

  aes_sub_word u_sub_word (
    .word_in  ({w3[23:0], w3[31:24]}),
    .word_out (sub_rot)
  );

  assign n0       = w0 ^ sub_rot ^ {RCON[cnt_q], 24'h0};
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    if (key_load) begin
      state_d  = EXPAND;
      cnt_d    = 4'd1;
      rk_d[0]  = key_in;
    end else if (state_q == EXPAND) begin
      for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
        if (cnt_q == 4'(i)) rk_d[i] = next_key;
      end
      if (cnt_q == LAST_IDX) begin
        state_d = READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_d[i];
    end
  end

  always_comb begin
    round_key_input = '0;
    for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
      if (round_key_addr == 4'(i)) round_key_input = rk_q[i];
    end
  end

  assign round_key_0 = rk_q[0];
  assign key_ready   = (state_q == READY);
  assign key_busy    = (state_q == EXPAND);

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion: expected values are queued as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   round_key_addr = '0;
  logic [127:0] round_key_input;
  logic [127:0] round_key_0;
  logic         key_ready;
  logic         key_busy;

  aes_key_expansion #(.NUM_ROUNDS(10)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .key_load        (key_load),
    .key_in          (key_in),
    .round_key_addr  (round_key_addr),
    .round_key_input (round_key_input),
    .round_key_0     (round_key_0),
    .key_ready       (key_ready),
    .key_busy        (key_busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int unsigned  checks = 0;
  int unsigned  passes = 0;
  logic [127:0] exp_q [$];

  task automatic expect_v(input logic [127:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [127:0] obs);
    logic [127:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_busy, input logic exp_ready);
    expect_v({127'b0, exp_busy});
    expect_v({127'b0, exp_ready});
    check({tag, "_busy"}, {127'b0, key_busy});
    check({tag, "_ready"}, {127'b0, key_ready});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [127:0] e);
    round_key_addr = addr;
    expect_v(e);
    @(negedge clk);
    check(tag, round_key_input);
  endtask

  task automatic sweep_fips(input string tag);
    logic [127:0] e;
    for (int i = 0; i < 16; i++) begin
      e = (i <= 10) ? FIPS_RK[i] : '0;
      read_check($sformatf("%s_addr%0d", tag, i), 4'(i), e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d passes=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_status("reset", 1'b0, 1'b0);
    expect_v('0);
    check("reset_rk0", round_key_0);
    read_check("reset_rd0", 4'd0, '0);
    n_rst = 1'b1;
    @(negedge clk);

    // FIPS-197 key: latency and contents
    do_load(FIPS_KEY);
    check_status("lat_e0", 1'b1, 1'b0);
    for (int j = 1; j <= 9; j++) begin
      tick();
      check_status($sformatf("lat_e%0d", j), 1'b1, 1'b0);
    end
    tick();
    check_status("lat_e10", 1'b0, 1'b1);
    expect_v(FIPS_KEY);
    check("fips_rk0", round_key_0);
    read_check("fips_rk1", 4'd1, FIPS_RK[1]);
    read_check("fips_rk10", 4'd10, FIPS_RK[10]);

    // Full address sweep while READY
    sweep_fips("sweep");

    // Zero key loaded while READY
    @(posedge clk); #1;
    do_load('0);
    check_status("zero_e0", 1'b1, 1'b0);
    repeat (10) tick();
    check_status("zero_done", 1'b0, 1'b1);
    expect_v('0);
    check("zero_rk0", round_key_0);
    read_check("zero_rk1", 4'd1, ZERO_RK1);
    read_check("zero_rk10", 4'd10, ZERO_RK10);

    // Abort mid-expansion, then FIPS reload held high for two cycles
    @(posedge clk); #1;
    do_load(FIPS_KEY);
    repeat (3) tick();
    do_load('0);
    repeat (3) tick();
    check_status("abort_mid", 1'b1, 1'b0);
    key_in   = FIPS_KEY;
    key_load = 1'b1;
    tick();
    tick();
    key_load = 1'b0;
    check_status("reload_e0", 1'b1, 1'b0);
    for (int j = 1; j <= 9; j++) begin
      tick();
      check_status($sformatf("reload_e%0d", j), 1'b1, 1'b0);
    end
    tick();
    check_status("reload_e10", 1'b0, 1'b1);
    sweep_fips("reload");

    // Asynchronous reset mid-expansion
    @(posedge clk); #1;
    do_load(FIPS_KEY);
    repeat (4) tick();
    #2 n_rst = 1'b0;
    #1;
    check_status("arst", 1'b0, 1'b0);
    expect_v('0);
    check("arst_rk0", round_key_0);
    round_key_addr = 4'd1;
    expect_v('0);
    #1 check("arst_rd1", round_key_input);
    round_key_addr = 4'd10;
    expect_v('0);
    #1 check("arst_rd10", round_key_input);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) tick();
    check_status("idle_after_rst", 1'b0, 1'b0);
    expect_v('0);
    check("idle_rk0", round_key_0);

    // Block resumes normally after reset
    do_load(FIPS_KEY);
    repeat (10) tick();
    check_status("post_rst_done", 1'b0, 1'b1);
    read_check("post_rst_rk10", 4'd10, FIPS_RK[10]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
